// File: rtl/tcb_lib_unaligned_split.sv
// Unaligned TCB manager to aligned TCB subordinate bridge; splits word-crossing transfers.
// Optional split counter port sts_cnt enabled by TCB_LIB_UNALIGNED_SPLIT_STAT_EN.
module tcb_lib_unaligned_split #(
  parameter  int ABW = 32,
  parameter  int DBW = 32,
  parameter  int DLY = 1,
  localparam int BEN = DBW/8,
  localparam int SZW = $clog2($clog2(BEN)+1)
)(
  input  logic           clk,
  input  logic           rst,
`ifdef TCB_LIB_UNALIGNED_SPLIT_STAT_EN
  output logic [15:0]    sts_cnt,
`endif
  input  logic           up_vld,
  input  logic           up_wen,
  input  logic [ABW-1:0] up_adr,
  input  logic [SZW-1:0] up_siz,
  input  logic           up_ndn,
  input  logic [DBW-1:0] up_wdt,
  output logic           up_rdy,
  output logic [DBW-1:0] up_rdt,
  output logic           up_err,
  output logic           dn_vld,
  output logic           dn_wen,
  output logic [ABW-1:0] dn_adr,
  output logic [BEN-1:0] dn_byt,
  output logic [DBW-1:0] dn_wdt,
  input  logic           dn_rdy,
  input  logic [DBW-1:0] dn_rdt,
  input  logic           dn_err
);

  localparam int OW = $clog2(BEN);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t          r_state;
  state_t          w_next;

  logic [OW-1:0]   w_off;
  logic [OW+1:0]   w_n;
  logic            w_crs;
  logic [ABW-1:0]  w_base;
  logic [DBW-1:0]  w_wdt;
  logic [BEN-1:0]  w_msk;
  logic [BEN-1:0]  w_hi;
  logic            w_hs;

  logic            w_rv;
  logic            w_rfin;
  logic [OW-1:0]   w_roff;
  logic [SZW-1:0]  w_rsiz;
  logic            w_rndn;
  logic            w_rcrs;
  logic            w_rwen;

  logic [DBW-1:0]  r_buf;
  logic            r_ebf;
  logic [DBW-1:0]  w_wrd;
  logic [DBW-1:0]  w_mrg;

  assign w_off  = up_adr[OW-1:0];
  assign w_n    = (OW+2)'(1) << up_siz;
  assign w_crs  = ({2'b00, w_off} + w_n) > (OW+2)'(BEN);
  assign w_base = {up_adr[ABW-1:OW], {OW{1'b0}}};

  // memory byte k sits on lane (off+k) mod BEN; w_hi marks first-part lanes
  always_comb begin
    int o, n, k;
    o = int'(w_off);
    n = int'(w_n);
    k = 0;
    w_wdt = '0;
    w_msk = '0;
    w_hi  = '0;
    for (int l = 0; l < BEN; l++) begin
      k = (l + BEN - o) % BEN;
      w_hi[l] = (l >= o);
      if (k < n) begin
        w_msk[l] = 1'b1;
        w_wdt[8*l +: 8] = up_ndn ? up_wdt[8*(n-1-k) +: 8]
                                 : up_wdt[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (up_vld && w_crs && dn_rdy) w_next = SECOND;
      SECOND:  if (dn_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dn_vld = 1'b0;
    up_rdy = 1'b0;
    dn_byt = w_msk & w_hi;
    dn_adr = w_base;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          dn_vld = up_vld;
          up_rdy = dn_rdy && !w_crs;
        end
        SECOND: begin
          dn_vld = 1'b1;
          up_rdy = dn_rdy;
          dn_byt = w_msk & ~w_hi;
          dn_adr = w_base + ABW'(BEN);
        end
        default: ;
      endcase
    end
  end

  assign dn_wen = up_wen;
  assign dn_wdt = w_wdt;
  assign w_hs   = dn_vld && dn_rdy;

  generate
    if (DLY == 0) begin : g_d0
      assign w_rv   = w_hs;
      assign w_rfin = up_rdy;
      assign w_roff = w_off;
      assign w_rsiz = up_siz;
      assign w_rndn = up_ndn;
      assign w_rcrs = (r_state == SECOND) || w_crs;
      assign w_rwen = up_wen;
    end else begin : g_d1
      logic           r_rv, r_rfin, r_rndn, r_rcrs, r_rwen;
      logic [OW-1:0]  r_roff;
      logic [SZW-1:0] r_rsiz;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rv   <= 1'b0;
          r_rfin <= 1'b0;
          r_roff <= '0;
          r_rsiz <= '0;
          r_rndn <= 1'b0;
          r_rcrs <= 1'b0;
          r_rwen <= 1'b0;
        end else begin
          r_rv   <= w_hs;
          r_rfin <= up_rdy;
          r_roff <= w_off;
          r_rsiz <= up_siz;
          r_rndn <= up_ndn;
          r_rcrs <= (r_state == SECOND) || w_crs;
          r_rwen <= up_wen;
        end
      end
      assign w_rv   = r_rv;
      assign w_rfin = r_rfin;
      assign w_roff = r_roff;
      assign w_rsiz = r_rsiz;
      assign w_rndn = r_rndn;
      assign w_rcrs = r_rcrs;
      assign w_rwen = r_rwen;
    end
  endgenerate

  // first-part response is parked here until the final part returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_ebf <= 1'b0;
    end else if (w_rv && !w_rfin) begin
      r_buf <= dn_rdt;
      r_ebf <= dn_err;
    end
  end

  always_comb begin
    int o, n, s;
    o = int'(w_roff);
    n = 1 << int'(w_rsiz);
    s = 0;
    w_wrd = '0;
    w_mrg = '0;
    for (int l = 0; l < BEN; l++) begin
      w_wrd[8*l +: 8] = (w_rcrs && l >= o) ? r_buf[8*l +: 8]
                                           : dn_rdt[8*l +: 8];
    end
    for (int j = 0; j < BEN; j++) begin
      if (j < n) begin
        s = w_rndn ? (n - 1 - j) : j;
        w_mrg[8*j +: 8] = w_wrd[8*((o + s) % BEN) +: 8];
      end
    end
  end

  assign up_rdt = (!rst && w_rv && w_rfin && !w_rwen) ? w_mrg : '0;
  assign up_err = !rst && w_rv && w_rfin &&
                  (dn_err || (w_rcrs && r_ebf));

`ifdef TCB_LIB_UNALIGNED_SPLIT_STAT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_hs && r_state == SECOND && r_cnt != 16'hFFFF)
      r_cnt <= r_cnt + 16'd1;
  end
  assign sts_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_tcb_lib_unaligned_split.sv
// Bench for tcb_lib_unaligned_split: byte-memory subordinate plus upstream-level reference.
// Directed cases followed by randomized transfers.
module tb_tcb_lib_unaligned_split;

  localparam int ABW = 32;
  localparam int DBW = 32;
  localparam int DLY = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_vld = 1'b0, up_wen = 1'b0, up_ndn = 1'b0;
  logic [31:0] up_adr = '0, up_wdt = '0;
  logic [1:0]  up_siz = '0;
  logic        up_rdy, up_err;
  logic [31:0] up_rdt;
  logic        dn_vld, dn_wen;
  logic [31:0] dn_adr, dn_wdt;
  logic [3:0]  dn_byt;
  logic        dn_rdy = 1'b0, dn_err = 1'b0;
  logic [31:0] dn_rdt = '0;
`ifdef TCB_LIB_UNALIGNED_SPLIT_STAT_EN
  logic [15:0] sts_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] smem [0:1023];
  logic [7:0] rmem [0:1023];

  tcb_lib_unaligned_split #(.ABW(ABW), .DBW(DBW), .DLY(DLY)) dut (
    .clk(clk), .rst(rst),
`ifdef TCB_LIB_UNALIGNED_SPLIT_STAT_EN
    .sts_cnt(sts_cnt),
`endif
    .up_vld(up_vld), .up_wen(up_wen), .up_adr(up_adr),
    .up_siz(up_siz), .up_ndn(up_ndn), .up_wdt(up_wdt),
    .up_rdy(up_rdy), .up_rdt(up_rdt), .up_err(up_err),
    .dn_vld(dn_vld), .dn_wen(dn_wen), .dn_adr(dn_adr),
    .dn_byt(dn_byt), .dn_wdt(dn_wdt), .dn_rdy(dn_rdy),
    .dn_rdt(dn_rdt), .dn_err(dn_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(logic [31:0] a, logic [1:0] s,
                                         logic e);
    int n, ai;
    logic [31:0] r;
    n = 1 << s;
    ai = int'(a[9:0]);
    r = '0;
    for (int j = 0; j < n; j++)
      r[8*j +: 8] = rmem[(ai + (e ? n-1-j : j)) % 1024];
    return r;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [1:0] s,
                          input logic e, input logic [31:0] d);
    int n, ai;
    n = 1 << s;
    ai = int'(a[9:0]);
    for (int j = 0; j < n; j++)
      rmem[(ai + (e ? n-1-j : j)) % 1024] = d[8*j +: 8];
  endtask

  function automatic int mem_diff();
    int c;
    c = 0;
    for (int i = 0; i < 1024; i++)
      if (smem[i] !== rmem[i]) c++;
    return c;
  endfunction

  task automatic req(input logic w, input logic [31:0] a,
                     input logic [1:0] s, input logic e,
                     input logic [31:0] d, input int st0, input int st1,
                     input logic er0, input logic er1,
                     output int nhs,
                     output logic [3:0] b0, output logic [3:0] b1,
                     output logic [31:0] w0, output logic [31:0] w1,
                     output logic [31:0] rdt, output logic err);
    int ehs, stl, scyc, ai;
    logic pend, pe, done;
    logic [31:0] prd, aw;
    logic [69:0] hold;
    ai = int'(a[1:0]);
    ehs = (ai + (1 << s) > 4) ? 2 : 1;
    nhs = 0; stl = 0; scyc = 0;
    pend = 0; pe = 0; done = 0; prd = '0; hold = '0;
    b0 = '0; b1 = '0; w0 = '0; w1 = '0;
    aw = {a[31:2], 2'b00};
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      up_vld = 1'b1; up_wen = w; up_adr = a;
      up_siz = s; up_ndn = e; up_wdt = d;
      dn_rdt = pend ? prd : $urandom;
      dn_err = pend ? pe : ($urandom % 2 == 1);
      pend = 1'b0;
      dn_rdy = (stl < (nhs == 0 ? st0 : st1)) ? 1'b0 : 1'b1;
      if (!dn_rdy) stl++;
      #1;
      if (nhs == 1) begin
        if (scyc == 0)
          hold = {dn_vld, dn_wen, dn_adr, dn_byt, dn_wdt};
        else
          chk("stall_hold", {dn_vld, dn_wen, dn_adr, dn_byt, dn_wdt}, hold);
        scyc++;
      end
      if (dn_vld && dn_rdy) begin
        chk("dn_adr", dn_adr, aw + 32'(4 * nhs));
        chk("up_rdy", up_rdy, (nhs + 1 == ehs));
        for (int l = 0; l < 4; l++) begin
          if (w && dn_byt[l]) smem[(dn_adr + l) % 1024] = dn_wdt[8*l +: 8];
          prd[8*l +: 8] = smem[(dn_adr + l) % 1024];
        end
        pe = (nhs == 0) ? er0 : er1;
        pend = 1'b1;
        if (nhs == 0) begin b0 = dn_byt; w0 = dn_wdt; end
        else          begin b1 = dn_byt; w1 = dn_wdt; end
        nhs++;
        stl = 0;
        if (up_rdy) done = 1'b1;
      end
    end
    chk("req_done", done, 1'b1);
    @(negedge clk);
    up_vld = 1'b0; dn_rdy = 1'b0;
    dn_rdt = prd; dn_err = pe;
    #1;
    rdt = up_rdt;
    err = up_err;
  endtask

  initial begin
    int nhs;
    logic [3:0] b0, b1;
    logic [31:0] w0, w1, rdt, exp;
    logic err;
    logic w, e, er0, er1;
    logic [31:0] a, d;
    logic [1:0] s;
    int ai, crs;
`ifdef TCB_LIB_UNALIGNED_SPLIT_STAT_EN
    logic [15:0] c0;
`endif

    for (int i = 0; i < 1024; i++) begin
      smem[i] = 8'($urandom);
      rmem[i] = smem[i];
    end
    for (int i = 0; i < 4; i++) begin
      smem[256 + i] = 8'(32'hAABBCCDD >> (8*i));
      smem[260 + i] = 8'(32'h11223344 >> (8*i));
      rmem[256 + i] = smem[256 + i];
      rmem[260 + i] = smem[260 + i];
    end

    // reset must gate everything even with a live request
    up_vld = 1'b1; up_adr = 32'h102; up_siz = 2'd2; dn_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dn_vld", dn_vld, 1'b0);
    chk("rst_up_rdy", up_rdy, 1'b0);
    chk("rst_up_rdt", up_rdt, 32'h0);
    chk("rst_up_err", up_err, 1'b0);
    @(negedge clk);
    up_vld = 1'b0; dn_rdy = 1'b0; rst = 1'b0;

    req(0, 32'h100, 2, 0, 0, 0, 0, 0, 0, nhs, b0, b1, w0, w1, rdt, err);
    chk("al_nhs", nhs, 1);
    chk("al_byt", b0, 4'b1111);
    chk("al_rdt", rdt, 32'hAABBCCDD);
    chk("al_err", err, 1'b0);

    req(0, 32'h102, 2, 0, 0, 0, 0, 0, 0, nhs, b0, b1, w0, w1, rdt, err);
    chk("le_nhs", nhs, 2);
    chk("le_rdt", rdt, 32'h3344AABB);

    req(0, 32'h102, 2, 1, 0, 1, 0, 0, 0, nhs, b0, b1, w0, w1, rdt, err);
    chk("be_rdt", rdt, 32'hBBAA4433);

`ifdef TCB_LIB_UNALIGNED_SPLIT_STAT_EN
    c0 = sts_cnt;
`endif
    req(0, 32'h102, 2, 0, 0, 0, 3, 1, 0, nhs, b0, b1, w0, w1, rdt, err);
    chk("stl_nhs", nhs, 2);
    chk("stl_rdt", rdt, 32'h3344AABB);
    chk("stl_err", err, 1'b1);
`ifdef TCB_LIB_UNALIGNED_SPLIT_STAT_EN
    chk("sts_cnt", sts_cnt, c0 + 16'd1);
`endif

    req(1, 32'h103, 1, 0, 32'hBEEF, 0, 1, 0, 0, nhs, b0, b1, w0, w1, rdt, err);
    model_wr(32'h103, 1, 0, 32'hBEEF);
    chk("hw_nhs", nhs, 2);
    chk("hw_byt0", b0, 4'b1000);
    chk("hw_wdt0", w0[31:24], 8'hEF);
    chk("hw_byt1", b1, 4'b0001);
    chk("hw_wdt1", w1[7:0], 8'hBE);
    chk("hw_rdt", rdt, 32'h0);
    chk("hw_mem", mem_diff(), 0);

    // abandon a split by reset while the second part is pending
    @(negedge clk);
    up_vld = 1'b1; up_wen = 1'b0; up_adr = 32'h102;
    up_siz = 2'd2; up_ndn = 1'b0; dn_rdy = 1'b1;
    #1;
    chk("ar_first_vld", dn_vld, 1'b1);
    chk("ar_first_rdy", up_rdy, 1'b0);
    @(negedge clk);
    dn_rdy = 1'b0;
    #1;
    chk("ar_sec_vld", dn_vld, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_rst_vld", dn_vld, 1'b0);
    chk("ar_rst_rdy", up_rdy, 1'b0);
    @(negedge clk);
    up_vld = 1'b0; rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ar_idle_vld", dn_vld, 1'b0);

    req(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, nhs, b0, b1, w0, w1, rdt, err);
    chk("by_nhs", nhs, 1);
    chk("by_byt", b0, 4'b0001);
    chk("by_rdt", rdt, {24'h0, rmem[512]});

    for (int it = 0; it < 250; it++) begin
      w = ($urandom % 2 == 1);
      a = $urandom_range(0, 1019);
      s = 2'($urandom_range(0, 2));
      e = ($urandom % 2 == 1);
      d = $urandom;
      er0 = ($urandom % 4 == 0);
      er1 = ($urandom % 4 == 0);
      ai = int'(a[1:0]);
      crs = (ai + (1 << s) > 4) ? 1 : 0;
      exp = w ? 32'h0 : exp_rd(a, s, e);
      req(w, a, s, e, d, $urandom_range(0, 2), $urandom_range(0, 2),
          er0, er1, nhs, b0, b1, w0, w1, rdt, err);
      chk("rnd_nhs", nhs, crs + 1);
      chk("rnd_rdt", rdt, exp);
      chk("rnd_err", err, crs ? (er0 | er1) : er0);
      if (w) begin
        model_wr(a, s, e, d);
        chk("rnd_mem", mem_diff(), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tcb_lib_unaligned_split.md
Name: tcb_lib_unaligned_split

Overview:
- Bridges an unaligned-capable TCB manager (reference mode, LSB-aligned data, logarithmic size) to an aligned-only TCB subordinate (memory mode, byte enables).
- Transfers that fit in one DBW-wide word pass through in a single downstream transfer with byte-lane steering.
- Transfers that cross a word boundary are split into two downstream transfers. Read data is merged and error responses are combined.
- Sits between a CPU load/store unit and SRAM or peripheral interconnect.

Parameters:
- ABW, 32, address bus width.
- DBW, 32, data bus width; power of two, 16..128.
- DLY, 1, downstream and upstream response delay in cycles; legal values 0 or 1.
- BEN = DBW/8, derived (localparam), number of byte lanes.
- SZW = $clog2($clog2(BEN)+1), derived (localparam), width of the size field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- up_vld  in  1  upstream request valid
- up_wen  in  1  write enable
- up_adr  in  ABW  byte address, any alignment
- up_siz  in  SZW  logarithmic size; 2^siz bytes, max BEN
- up_ndn  in  1  endianness; 0 little, 1 big
- up_wdt  in  DBW  write data, LSB aligned
- up_rdy  out  1  request accepted
- up_rdt  out  DBW  read data, LSB aligned, valid DLY cycles after final acceptance
- up_err  out  1  error response, same timing as up_rdt
- dn_vld  out  1  downstream request valid
- dn_wen  out  1  write enable
- dn_adr  out  ABW  word-aligned address; low $clog2(BEN) bits are 0
- dn_byt  out  BEN  byte enables
- dn_wdt  out  DBW  lane-positioned write data
- dn_rdy  in  1  downstream ready
- dn_rdt  in  DBW  downstream read data, DLY cycles after handshake
- dn_err  in  1  downstream error, same timing as dn_rdt

Behaviour:
- Handshake on both sides: a transfer occurs when vld && rdy. The manager holds the request stable until up_rdy.
- Decode:
  - off = up_adr mod BEN; n = 2^up_siz.
  - Crossing when off+n > BEN.
  - Memory byte k (k = 0..n-1) maps to address up_adr+k.
  - Little endian: upstream byte k ↔ memory adr+k.
  - Big endian: upstream byte n-1-k ↔ memory adr+k.
- FSM states:
  - IDLE
    - Non-crossing: dn_vld = up_vld and up_rdy = dn_rdy, both combinational. dn_byt covers lanes off..off+n-1.
    - Crossing: dn_vld = up_vld and up_rdy = 0. Drives first part: dn_adr = word(up_adr), lanes off..BEN-1. On dn handshake → SECOND.
  - SECOND
    - dn_vld = 1; drives second part: dn_adr = word(up_adr)+BEN, lanes 0..off+n-BEN-1.
    - up_rdy = dn_rdy. On handshake → IDLE.
- Read merge:
  - The first part's lanes are captured into a buffer register together with its err bit. Capture happens at the first handshake when DLY=0, one cycle later when DLY=1.
  - At response time, up_rdt combines the buffer lanes and the live dn_rdt lanes, rotated to LSB and endian-ordered.
  - Bytes above n in up_rdt are 0.
  - up_err = OR of both parts' err.
  - Non-crossing responses pass through, rotated.
- Writes: up_err is the OR of both parts' errors; up_rdt = 0.
- Response pipeline:
  - A DLY-deep flag records "final part" plus the lane map.
  - Upstream response timing is relative to the final handshake only; the intermediate first-part response is not forwarded.
- Reset (async, any state):
  - State → IDLE.
  - Buffer, err buffer and response pipeline → 0.
  - While rst is high: dn_vld = 0, up_rdy = 0, up_rdt = 0, up_err = 0.
  - A split in progress is abandoned; no second part is issued.
- Back-to-back: a new request may be accepted in the cycle after a final handshake. The response pipeline sustains one transfer per cycle.
- dn_rdy low in SECOND: hold every dn_* output stable.

Optional Feature:
- Macro: TCB_LIB_UNALIGNED_SPLIT_STAT_EN.
- Defined:
  - Adds output port sts_cnt[15:0], the count of split transfers.
  - Increments on each final handshake in SECOND and saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan (DBW=32, DLY=1):
- Aligned word read at 0x100; dn_rdt = 0xAABBCCDD → one dn transfer (adr 0x100, byt 4'b1111); up_rdt = 0xAABBCCDD one cycle later; up_rdy in the same cycle as dn_rdy.
- Half write at 0x103, little endian, up_wdt = 0xBEEF:
  - first dn transfer: adr 0x100, byt 4'b1000, wdt[31:24] = 0xEF;
  - second dn transfer: adr 0x104, byt 4'b0001, wdt[7:0] = 0xBE;
  - up_rdy only on the second handshake.
- Word read at 0x102, little endian; dn_rdt first = 0xAABBCCDD, second = 0x11223344 → up_rdt = 0x3344AABB.
- Same read with up_ndn = 1 → up_rdt = 0xBBAA4433.
- Crossing read with dn_err = 1 on the first part only and dn_rdy low for 3 cycles in SECOND → dn_* outputs stable during the stall; up_err = 1 on the final response. With the STAT macro defined, sts_cnt increments by 1.
- rst asserted while in SECOND → dn_vld = 0 immediately. After release, an aligned byte read at 0x200 completes as a single transfer with byt 4'b0001.
